// File: rtl/sel_pipe_mux.sv
// rtl/sel_pipe_mux.sv - registered N-way valid/ready selector with explicit and round-robin modes
module sel_pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_en,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] last_grant_q;

  logic             load_ok;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // A full register that is being drained this cycle may be refilled on the same edge.
  assign load_ok = !out_valid_q || out_ready;
  assign xfer    = grant_vld && load_ok;

  // Pick the winner: sel in explicit mode, otherwise the first valid input after last_grant
  // (indices above last_grant first, then wrap to the lowest index up to last_grant).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (rr_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_vld && in_valid[i] && (SEL_W'(i) > last_grant_q)) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_vld && in_valid[i] && (SEL_W'(i) <= last_grant_q)) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Out-of-range sel matches no lane, so it simply yields no grant.
      for (int i = 0; i < NUM_IN; i++) begin
        if ((sel == SEL_W'(i)) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
  end

  // Steer the granted lane's data and raise exactly one ready; nothing is accepted during reset.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
      in_ready[i] = rst_n && xfer && (grant_idx == SEL_W'(i));
    end
  end

  // Output register and round-robin pointer; last_grant tracks grants in both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SEL_W'(NUM_IN - 1);
    end else if (xfer) begin
      out_data_q   <= grant_data;
      out_src_q    <= grant_idx;
      out_valid_q  <= 1'b1;
      last_grant_q <= grant_idx;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// tb/tb_sel_pipe_mux.sv - randomized self-checking bench for sel_pipe_mux
module tb_sel_pipe_mux;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SW-1:0]   sel;
  logic            rr_en;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_src;
  logic            out_valid;
  logic            out_ready;

  logic [23:0]     d3_data;
  logic [2:0]      d3_valid;
  logic [2:0]      d3_ready;
  logic [1:0]      d3_sel;
  logic            d3_rr;
  logic [7:0]      d3_odata;
  logic [1:0]      d3_src;
  logic            d3_ovalid;
  logic            d3_oready;

  always #5 clk = ~clk;

  sel_pipe_mux #(.WIDTH(W), .NUM_IN(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .rr_en(rr_en), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  sel_pipe_mux #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(d3_valid), .in_ready(d3_ready),
    .sel(d3_sel), .rr_en(d3_rr), .out_data(d3_odata), .out_src(d3_src),
    .out_valid(d3_ovalid), .out_ready(d3_oready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_src;
  int         m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Grant per the selection rules: -1 means no grant.
  function automatic int model_grant();
    int j;
    if (!rr_en) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int off = 1; off <= N; off++) begin
      j = (m_last + off) % N;
      if (in_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] lane(input int i);
    return in_data[i*W +: W];
  endfunction

  task automatic set_lane(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  // One clock: check handshake/outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input string tag);
    int g;
    bit ld;
    logic [N-1:0] er;
    @(negedge clk);
    g  = model_grant();
    ld = !m_valid || out_ready;
    er = '0;
    if (g >= 0 && ld) er[g] = 1'b1;
    check({tag, ".in_ready"},  64'(in_ready),  64'(er));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".out_data"},  64'(out_data),  64'(m_data));
    check({tag, ".out_src"},   64'(out_src),   64'(m_src));
    @(posedge clk);
    #1;
    if (g >= 0 && ld) begin
      m_valid = 1'b1;
      m_data  = lane(g);
      m_src   = g;
      m_last  = g;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".rst_data"},  64'(out_data),  64'd0);
    check({tag, ".rst_src"},   64'(out_src),   64'd0);
    check({tag, ".rst_ready"}, 64'(in_ready),  64'd0);
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_last  = N - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_data   = '0;
    in_valid  = '1;
    sel       = '0;
    rr_en     = 1'b1;
    out_ready = 1'b1;
    d3_data   = 24'h332211;
    d3_valid  = 3'b111;
    d3_sel    = 2'd3;
    d3_rr     = 1'b0;
    d3_oready = 1'b1;
    for (int i = 0; i < N; i++) set_lane(i, W'(32'h100 + i));
    do_reset("init");

    // round-robin fairness from reset
    for (int k = 0; k < 8; k++) begin
      cycle("rr");
      check("rr.seq", 64'(out_src), 64'(k % N));
    end

    // reset mid-stream while the register is full, then fairness restarts at 0
    check("mid.full", 64'(out_valid), 64'd1);
    do_reset("mid");
    cycle("post");
    check("post.first_src", 64'(out_src), 64'd0);

    // explicit select
    rr_en = 1'b0;
    sel   = 2'd2;
    set_lane(2, 32'hDEADBEEF);
    #1;
    check("expl.ready", 64'(in_ready), 64'b0100);
    cycle("expl");
    check("expl.data", 64'(out_data), 64'hDEADBEEF);
    check("expl.src",  64'(out_src),  64'd2);

    // backpressure: fill from input 1, stall 3 cycles with input 3 pending
    sel      = 2'd1;
    in_valid = 4'b0010;
    set_lane(1, 32'h11);
    set_lane(3, 32'h3333_0003);
    cycle("bp_fill");
    sel       = 2'd3;
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle("bp_stall");
      check("bp.hold", 64'(out_data), 64'h11);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'b1000);
    cycle("bp_rel");
    check("bp.new_data", 64'(out_data), 64'h3333_0003);

    // mode switch: explicit grant of 2, then round-robin resumes after 2
    sel      = 2'd2;
    in_valid = 4'b0100;
    cycle("ms_expl");
    rr_en    = 1'b1;
    in_valid = 4'b1001;
    cycle("ms_rr1");
    check("ms.first", 64'(out_src), 64'd3);
    cycle("ms_rr2");
    check("ms.second", 64'(out_src), 64'd0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = N'($urandom);
      sel       = SW'($urandom);
      rr_en     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    // NUM_IN=3 with sel=3 never grants
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("inv.ready", 64'(d3_ready),  64'd0);
      check("inv.valid", 64'(d3_ovalid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sel_pipe_mux.md
# sel_pipe_mux

Parametrised, registered N-way data selector with valid/ready handshakes on every input and on the output; the generalised successor of the CPU's 32-bit 2:1 datapath mux. It supports two selection modes:
- explicit-select mode, where `sel` steers the path, as the combinational mux does;
- round-robin mode, which arbitrates among valid inputs for shared datapath resources such as the writeback and memory-request paths.

The output is a single-entry register, so the block also breaks the timing path between producers and the consumer.

## Interface
- `WIDTH`, 32: data width per input, ≥1.
- `NUM_IN`, 4: number of inputs, ≥2, need not be a power of 2.
- `SEL_W`, localparam: derived as `clog2(NUM_IN)` (1 when `NUM_IN`=2).

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_data`  in  `NUM_IN*WIDTH`: input `i` occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  `NUM_IN`: input `i` presents data.
- `in_ready`  out  `NUM_IN`: input `i` is accepted this cycle; one-hot or zero.
- `sel`  in  `SEL_W`: index of the input to pass in explicit mode.
- `rr_en`  in  1: 0 selects explicit mode, 1 selects round-robin mode.
- `out_data`  out  `WIDTH`: registered selected data.
- `out_src`  out  `SEL_W`: index of the input that supplied `out_data`.
- `out_valid`  out  1: output register holds data.
- `out_ready`  in  1: consumer accepts data this cycle.

## Operation
- Output register: `out_data`, `out_src`, `out_valid`.
  - Reset values: `out_data`=0, `out_src`=0, `out_valid`=0. The internal `last_grant` resets to `NUM_IN`-1.
- Load permission: `load_ok` = `!out_valid || out_ready`. A full register being drained this cycle can be refilled in the same cycle.
- Grant (combinational, one-hot or none):
  - Explicit mode (`rr_en`=0): grant `sel` iff `sel` < `NUM_IN` and `in_valid[sel]`. Otherwise there is no grant, and `in_valid` of non-selected inputs is ignored.
  - Round-robin mode (`rr_en`=1): grant the first `i` with `in_valid[i]`=1, scanning `last_grant+1`, `last_grant+2`, … modulo `NUM_IN`. `last_grant` has lowest priority. If no input is valid, there is no grant.
- `in_ready[g]` = `load_ok` and `g` granted; all other bits are 0. Transfer on input `g` occurs when `in_valid[g]` and `in_ready[g]`.
- On transfer:
  - `out_data` ← input `g` data;
  - `out_src` ← `g`;
  - `out_valid` ← 1;
  - `last_grant` ← `g`. `last_grant` updates in both modes, so switching to round-robin resumes fairly.
- On output handshake with no new transfer: `out_valid` ← 0. `out_data` and `out_src` hold their last values.
- Stall (`out_valid`=1 and `out_ready`=0): `out_data` and `out_src` stay stable, and all `in_ready` bits are 0.
- Changing `sel` or `rr_en` affects only the next grant decision and never the held output.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). Held data is discarded, and `in_ready` goes to 0 while `rst_n`=0.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`=1.
- Throughput: 1 transfer per cycle when `out_ready` is held at 1.
- Combinational paths:
  - `in_valid`, `sel`, `rr_en`, `out_ready` → `in_ready`.
  - There is no combinational path from any input to `out_data`, `out_src`, or `out_valid`.
- Round-robin fairness: with all inputs continuously valid and `out_ready`=1, grants are 0,1,…,`NUM_IN`-1,0,… starting after reset. Each input waits at most `NUM_IN`-1 grants.
- `sel` ≥ `NUM_IN` (non-power-of-2 `NUM_IN`): no grant, no transfer, no error.
- Simultaneous drain and load: `out_valid` stays 1 and the register takes the new data in the same edge, with no bubble.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `out_valid`=1. Required: `out_valid`=0, `out_data`=0, `out_src`=0, and `in_ready`=0 before the next edge. After release with all inputs valid, `rr_en`=1, and `out_ready`=1, the first `out_src` is 0.
- Explicit mode: `WIDTH`=32, `NUM_IN`=4, `rr_en`=0, `sel`=2, `in_data[2]`=0xDEADBEEF, all inputs valid, `out_ready`=1. Required: `in_ready`=4'b0100, and the next cycle shows `out_data`=0xDEADBEEF, `out_src`=2.
- Round-robin mode: all 4 inputs valid, with data `i`+0x100, and `out_ready`=1 for 8 cycles. Required: `out_src` sequence 0,1,2,3,0,1,2,3 and one transfer per cycle.
- Backpressure: fill the output with input 1 (0x11), then hold `out_ready`=0 for 3 cycles while input 3 is valid. Required: `out_data`=0x11 stable, `in_ready`=0. When `out_ready` rises, the same cycle gives `in_ready[3]`=1, and the next cycle gives `out_data` = input 3 data.
- Invalid select: `NUM_IN`=3, `sel`=3, all inputs valid, `rr_en`=0. Required: `in_ready`=0 and `out_valid` stays 0.
- Mode switch: grant input 2 in explicit mode, then set `rr_en`=1 with inputs 0 and 3 valid. Required: the next grant is 3, then 0.
